// File: rtl/az_sample_collector_pkg.sv
// Shared AZ control encodings plus the phase/state types used by the sample collector.
// The modulator decodes the same encodings from this package.
package az_sample_collector_pkg;

    typedef enum logic {
        SW_PC_BOOT   = 1'b0,
        SW_PC_SIGNAL = 1'b1
    } sw_pc_e;

    typedef enum logic [2:0] {
        MUX_AZ_PC_OUT = 3'd0,
        MUX_AZ_ZERO   = 3'd7
    } mux_az_e;

    typedef enum logic [1:0] {
        PH_NONE,
        PH_SIG,
        PH_ZERO
    } phase_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SIG_ACC,
        ST_WAIT_ZERO,
        ST_ZERO_ACC,
        ST_EMIT,
        ST_ZERO_ORPHAN
    } state_e;

    function automatic phase_e decode_phase(input logic sw_pc_ctl, input logic [2:0] mux_az);
        if (mux_az == MUX_AZ_ZERO)
            return PH_ZERO;
        if (sw_pc_ctl == SW_PC_SIGNAL && mux_az == MUX_AZ_PC_OUT)
            return PH_SIG;
        return PH_NONE;
    endfunction

endpackage

// File: rtl/az_phase_accumulator.sv
// One phase worth of accumulation: settle-skip, saturating sample count, wrapping signed sum.
// A clear restarts the phase and may coincide with the phase's first sample.
module az_phase_accumulator #(
    parameter int ADC_W    = 24,
    parameter int ACC_W    = 40,
    parameter int CNT_W    = 16,
    parameter int SETTLE_N = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic             valid,
    input  logic [ADC_W-1:0] data,
    output logic [ACC_W-1:0] sum,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

    localparam int SET_W = (SETTLE_N > 1) ? $clog2(SETTLE_N + 1) : 1;

    logic [SET_W-1:0]        settle_cnt;
    logic [SET_W-1:0]        settle_base;
    logic signed [ACC_W-1:0] sum_base;
    logic signed [ACC_W-1:0] sum_add;
    logic signed [ACC_W-1:0] ext;
    logic [CNT_W-1:0]        count_base;
    logic                    in_settle;
    logic                    take;
    logic                    cnt_full;
    logic                    ovf;

    always_comb begin
        settle_base = clear ? '0 : settle_cnt;
        sum_base    = clear ? '0 : $signed(sum);
        count_base  = clear ? '0 : count;
        ext         = ACC_W'($signed(data));
        in_settle   = int'(settle_base) < SETTLE_N;
        take        = enable && valid && !in_settle;
        cnt_full    = &count_base;
        sum_add     = sum_base + ext;
        // Signed overflow: operands agree in sign, result does not.
        ovf         = (sum_base[ACC_W-1] == ext[ACC_W-1]) &&
                      (sum_add[ACC_W-1] != sum_base[ACC_W-1]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            settle_cnt <= '0;
            sum        <= '0;
            count      <= '0;
            sat        <= 1'b0;
        end else begin
            settle_cnt <= settle_base;
            sum        <= sum_base;
            count      <= count_base;
            sat        <= 1'b0;
            if (enable && valid && in_settle) begin
                settle_cnt <= settle_base + 1'b1;
            end else if (take) begin
                if (cnt_full) begin
                    sat <= 1'b1;
                end else begin
                    sum   <= sum_add;
                    count <= count_base + 1'b1;
                    sat   <= ovf;
                end
            end
        end
    end

endmodule

// File: rtl/az_sample_collector.sv
// Pairs signal and zero phases of the AZ modulation into one corrected result per pair.
// Inputs are registered once so the phase decode and the ADC sample stay aligned.
module az_sample_collector
    import az_sample_collector_pkg::*;
#(
    parameter int ADC_W    = 24,
    parameter int ACC_W    = 40,
    parameter int CNT_W    = 16,
    parameter int SETTLE_N = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sw_pc_ctl,
    input  logic [2:0]       mux_az,
    input  logic             adc_valid,
    input  logic [ADC_W-1:0] adc_data,
    input  logic             err_clear,
    output logic             out_valid,
    output logic [ACC_W-1:0] out_hi,
    output logic [ACC_W-1:0] out_lo,
    output logic [ACC_W-1:0] out_diff,
    output logic [CNT_W-1:0] out_hi_n,
    output logic [CNT_W-1:0] out_lo_n,
    output logic             err_orphan,
    output logic             err_sat
);

    logic             pc_q;
    logic [2:0]       mux_q;
    logic             valid_q;
    logic [ADC_W-1:0] data_q;
    phase_e           ph;
    phase_e           ph_q;
    state_e           state;
    state_e           state_d;

    logic             sig_clr, sig_en, zero_clr, zero_en;
    logic [ACC_W-1:0] sig_sum, zero_sum, hi_hold;
    logic [CNT_W-1:0] sig_cnt, zero_cnt, hi_n_hold;
    logic             sig_sat, zero_sat;
    logic             latch_hi, emit, set_orphan;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= 1'b0;
            mux_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            ph_q    <= PH_NONE;
        end else begin
            pc_q    <= sw_pc_ctl;
            mux_q   <= mux_az;
            valid_q <= adc_valid;
            data_q  <= adc_data;
            ph_q    <= ph;
        end
    end

    assign ph = decode_phase(pc_q, mux_q);

    // Accumulators restart on the first cycle of their phase, so the sample on
    // the transition cycle is already part of the new phase.
    assign sig_clr  = (ph == PH_SIG) && (ph_q != PH_SIG);
    assign sig_en   = (ph == PH_SIG);
    assign zero_clr = (ph == PH_ZERO) && (ph_q != PH_ZERO);
    assign zero_en  = (ph == PH_ZERO) &&
                      (state == ST_SIG_ACC || state == ST_WAIT_ZERO || state == ST_ZERO_ACC);

    az_phase_accumulator #(
        .ADC_W(ADC_W), .ACC_W(ACC_W), .CNT_W(CNT_W), .SETTLE_N(SETTLE_N)
    ) u_sig_acc (
        .clk(clk), .reset(reset), .clear(sig_clr), .enable(sig_en),
        .valid(valid_q), .data(data_q), .sum(sig_sum), .count(sig_cnt), .sat(sig_sat)
    );

    az_phase_accumulator #(
        .ADC_W(ADC_W), .ACC_W(ACC_W), .CNT_W(CNT_W), .SETTLE_N(SETTLE_N)
    ) u_zero_acc (
        .clk(clk), .reset(reset), .clear(zero_clr), .enable(zero_en),
        .valid(valid_q), .data(data_q), .sum(zero_sum), .count(zero_cnt), .sat(zero_sat)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_d;
    end

    // Direct jumps on one-cycle phases keep a short phase from being skipped.
    always_comb begin
        state_d    = state;
        latch_hi   = 1'b0;
        emit       = 1'b0;
        set_orphan = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (ph == PH_SIG)       state_d = ST_SIG_ACC;
                else if (ph == PH_ZERO) state_d = ST_ZERO_ORPHAN;
            end
            ST_SIG_ACC: begin
                if (ph != PH_SIG) begin
                    latch_hi = 1'b1;
                    state_d  = (ph == PH_ZERO) ? ST_ZERO_ACC : ST_WAIT_ZERO;
                end
            end
            ST_WAIT_ZERO: begin
                if (ph == PH_ZERO)     state_d = ST_ZERO_ACC;
                else if (ph == PH_SIG) state_d = ST_SIG_ACC;
            end
            ST_ZERO_ACC: begin
                if (ph != PH_ZERO) begin
                    emit    = 1'b1;
                    state_d = (ph == PH_SIG) ? ST_SIG_ACC : ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (ph == PH_SIG)       state_d = ST_SIG_ACC;
                else if (ph == PH_ZERO) state_d = ST_ZERO_ORPHAN;
                else                    state_d = ST_IDLE;
            end
            ST_ZERO_ORPHAN: begin
                if (ph != PH_ZERO) begin
                    set_orphan = 1'b1;
                    state_d    = (ph == PH_SIG) ? ST_SIG_ACC : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_hold    <= '0;
            hi_n_hold  <= '0;
            out_valid  <= 1'b0;
            out_hi     <= '0;
            out_lo     <= '0;
            out_diff   <= '0;
            out_hi_n   <= '0;
            out_lo_n   <= '0;
            err_orphan <= 1'b0;
            err_sat    <= 1'b0;
        end else begin
            if (latch_hi) begin
                hi_hold   <= sig_sum;
                hi_n_hold <= sig_cnt;
            end
            out_valid <= emit;
            if (emit) begin
                out_hi   <= hi_hold;
                out_hi_n <= hi_n_hold;
                out_lo   <= zero_sum;
                out_lo_n <= zero_cnt;
                out_diff <= hi_hold - zero_sum;
            end
            err_orphan <= set_orphan | (err_orphan & ~err_clear);
            err_sat    <= sig_sat | zero_sat | (err_sat & ~err_clear);
        end
    end

endmodule

// File: tb/tb_az_sample_collector.sv
// Bench for az_sample_collector: directed pair table, corner sequences, and a
// randomized phase stream checked against a phase-level pairing model.
`timescale 1ns/1ps
module tb_az_sample_collector;
    import az_sample_collector_pkg::*;

    localparam int ADC_W = 24, ACC_W = 40, CNT_W = 16, SETTLE_N = 2, S_CNT_W = 4;
    localparam int K_NONE = 0, K_SIG = 1, K_ZERO = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset, sw_pc_ctl, adc_valid, err_clear;
    logic [2:0]       mux_az;
    logic [ADC_W-1:0] adc_data;

    logic                    out_valid, err_orphan, err_sat;
    logic signed [ACC_W-1:0] out_hi, out_lo, out_diff;
    logic [CNT_W-1:0]        out_hi_n, out_lo_n;

    logic                    s_out_valid, s_err_orphan, s_err_sat;
    logic signed [ACC_W-1:0] s_out_hi, s_out_lo, s_out_diff;
    logic [S_CNT_W-1:0]      s_out_hi_n, s_out_lo_n;

    az_sample_collector #(.ADC_W(ADC_W), .ACC_W(ACC_W), .CNT_W(CNT_W), .SETTLE_N(SETTLE_N)) dut (
        .clk(clk), .reset(reset), .sw_pc_ctl(sw_pc_ctl), .mux_az(mux_az),
        .adc_valid(adc_valid), .adc_data(adc_data), .err_clear(err_clear),
        .out_valid(out_valid), .out_hi(out_hi), .out_lo(out_lo), .out_diff(out_diff),
        .out_hi_n(out_hi_n), .out_lo_n(out_lo_n), .err_orphan(err_orphan), .err_sat(err_sat)
    );

    az_sample_collector #(.ADC_W(ADC_W), .ACC_W(ACC_W), .CNT_W(S_CNT_W), .SETTLE_N(0)) dut_sat (
        .clk(clk), .reset(reset), .sw_pc_ctl(sw_pc_ctl), .mux_az(mux_az),
        .adc_valid(adc_valid), .adc_data(adc_data), .err_clear(err_clear),
        .out_valid(s_out_valid), .out_hi(s_out_hi), .out_lo(s_out_lo), .out_diff(s_out_diff),
        .out_hi_n(s_out_hi_n), .out_lo_n(s_out_lo_n), .err_orphan(s_err_orphan), .err_sat(s_err_sat)
    );

    int     checks = 0, failures = 0;
    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    // Result capture plus scoreboard comparison while random mode is on.
    typedef struct { longint cyc; longint hi; longint lo; int hn; int ln; } exp_t;
    exp_t   expq[$];
    bit     rnd_mode = 1'b0;
    int     n_valid = 0;
    longint cap_cyc = 0;
    always @(negedge clk) begin
        exp_t e;
        if (out_valid) begin
            n_valid++;
            cap_cyc = cyc;
            if (rnd_mode) begin
                if (expq.size() == 0) begin
                    chk("rnd_unexpected_valid", cyc, -1);
                end else begin
                    e = expq.pop_front();
                    chk("rnd_cycle", cyc, e.cyc);
                    chk("rnd_hi", out_hi, e.hi);
                    chk("rnd_lo", out_lo, e.lo);
                    chk("rnd_diff", out_diff, e.hi - e.lo);
                    chk("rnd_hi_n", out_hi_n, e.hn);
                    chk("rnd_lo_n", out_lo_n, e.ln);
                end
            end
        end
    end

    task automatic drive(input logic pc, input logic [2:0] mux, input logic v, input int d);
        sw_pc_ctl = pc; mux_az = mux; adc_valid = v; adc_data = ADC_W'(d);
        @(posedge clk); #1;
    endtask

    // n cycles with a sample each; n == 0 is a single cycle without a sample.
    task automatic phase(input int kind, input int n, input int val);
        for (int c = 0; c < ((n == 0) ? 1 : n); c++) begin
            case (kind)
                K_SIG:   drive(SW_PC_SIGNAL, MUX_AZ_PC_OUT, n != 0, val);
                K_ZERO:  drive(SW_PC_SIGNAL, MUX_AZ_ZERO, n != 0, val);
                default: drive(SW_PC_BOOT, MUX_AZ_PC_OUT, 1'b1, 12345);
            endcase
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; err_clear = 1'b0;
        phase(K_NONE, 2, 0);
        reset = 1'b0;
    endtask

    typedef struct {
        int sv; int sn; int gap; int zv; int zn;
        longint hi; longint lo; longint diff; int hn; int ln;
    } vec_t;
    vec_t tbl[5];

    int     nv0;
    longint t_end;
    bit     pending, exp_orph;
    longint p_sum, sum;
    int     p_n, n, seen, prev_kind, kind, len, d;
    logic   v;

    initial begin
        tbl[0] = '{1000, 6, 2, 10, 6, 4000, 40, 3960, 4, 4};
        tbl[1] = '{-500, 5, 1, 20, 5, -1500, 60, -1560, 3, 3};
        tbl[2] = '{3, 3, 0, 5, 0, 3, 0, 3, 1, 0};
        tbl[3] = '{9, 2, 3, -4, 7, 0, -20, 20, 0, 5};
        tbl[4] = '{-8388608, 10, 1, 8388607, 4, -67108864, 16777214, -83886078, 8, 2};

        reset = 1'b1; err_clear = 1'b0;
        sw_pc_ctl = 1'b0; mux_az = '0; adc_valid = 1'b0; adc_data = '0;
        phase(K_NONE, 2, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_hi", out_hi, 0);
        chk("rst_lo", out_lo, 0);
        chk("rst_diff", out_diff, 0);
        chk("rst_hi_n", out_hi_n, 0);
        chk("rst_lo_n", out_lo_n, 0);
        chk("rst_orphan", err_orphan, 0);
        chk("rst_sat", err_sat, 0);
        reset = 1'b0;

        foreach (tbl[i]) begin
            do_reset();
            nv0 = n_valid;
            phase(K_SIG, tbl[i].sn, tbl[i].sv);
            if (tbl[i].gap > 0) phase(K_NONE, tbl[i].gap, 0);
            phase(K_ZERO, tbl[i].zn, tbl[i].zv);
            t_end = cyc;
            phase(K_NONE, 4, 0);
            chk($sformatf("tbl%0d_npulse", i), n_valid - nv0, 1);
            chk($sformatf("tbl%0d_latency", i), cap_cyc - t_end, 2);
            chk($sformatf("tbl%0d_hi", i), out_hi, tbl[i].hi);
            chk($sformatf("tbl%0d_lo", i), out_lo, tbl[i].lo);
            chk($sformatf("tbl%0d_diff", i), out_diff, tbl[i].diff);
            chk($sformatf("tbl%0d_hi_n", i), out_hi_n, tbl[i].hn);
            chk($sformatf("tbl%0d_lo_n", i), out_lo_n, tbl[i].ln);
        end

        // Orphan zero; a clear on the same cycle as the set loses.
        do_reset();
        nv0 = n_valid;
        phase(K_ZERO, 10, 5);
        err_clear = 1'b1;
        phase(K_NONE, 2, 0);
        err_clear = 1'b0;
        phase(K_NONE, 1, 0);
        chk("orphan_set", err_orphan, 1);
        chk("orphan_no_valid", n_valid - nv0, 0);
        err_clear = 1'b1;
        phase(K_NONE, 1, 0);
        err_clear = 1'b0;
        chk("orphan_cleared", err_orphan, 0);

        // Repeated signal phase: only the second one pairs.
        do_reset();
        nv0 = n_valid;
        phase(K_SIG, 4, 100);
        phase(K_NONE, 2, 0);
        phase(K_SIG, 4, 7);
        phase(K_NONE, 1, 0);
        phase(K_ZERO, 4, 3);
        phase(K_NONE, 3, 0);
        chk("resig_npulse", n_valid - nv0, 1);
        chk("resig_hi", out_hi, 14);
        chk("resig_lo", out_lo, 6);
        chk("resig_diff", out_diff, 8);

        // Count saturation on the narrow instance.
        do_reset();
        phase(K_SIG, 20, 1);
        phase(K_NONE, 1, 0);
        phase(K_ZERO, 1, 2);
        phase(K_NONE, 3, 0);
        chk("sat_hi_n", s_out_hi_n, 15);
        chk("sat_hi", s_out_hi, 15);
        chk("sat_lo", s_out_lo, 2);
        chk("sat_err", s_err_sat, 1);
        chk("sat_wide_hi", out_hi, 18);
        chk("sat_wide_err", err_sat, 0);
        err_clear = 1'b1;
        phase(K_NONE, 1, 0);
        err_clear = 1'b0;
        chk("sat_err_cleared", s_err_sat, 0);

        // Reset in the middle of a zero phase, then a clean pair.
        do_reset();
        phase(K_SIG, 6, 1000);
        phase(K_NONE, 2, 0);
        phase(K_ZERO, 6, 10);
        phase(K_NONE, 3, 0);
        phase(K_SIG, 4, 50);
        phase(K_ZERO, 2, 5);
        reset = 1'b1;
        phase(K_ZERO, 1, 5);
        chk("midrst_valid", out_valid, 0);
        chk("midrst_hi", out_hi, 0);
        chk("midrst_lo", out_lo, 0);
        chk("midrst_diff", out_diff, 0);
        chk("midrst_hi_n", out_hi_n, 0);
        chk("midrst_lo_n", out_lo_n, 0);
        reset = 1'b0;
        nv0 = n_valid;
        phase(K_NONE, 2, 0);
        phase(K_SIG, 5, -500);
        phase(K_NONE, 1, 0);
        phase(K_ZERO, 5, 20);
        phase(K_NONE, 3, 0);
        chk("postrst_npulse", n_valid - nv0, 1);
        chk("postrst_hi", out_hi, -1500);
        chk("postrst_lo", out_lo, 60);
        chk("postrst_orphan", err_orphan, 0);

        // Random phase stream against a phase-level pairing model.
        do_reset();
        rnd_mode = 1'b1;
        pending = 1'b0; exp_orph = 1'b0; prev_kind = K_NONE;
        nv0 = n_valid;
        for (int s = 0; s < 120; s++) begin
            do kind = $urandom_range(0, 2); while (kind != K_NONE && kind == prev_kind);
            len = $urandom_range(1, 6);
            sum = 0; n = 0; seen = 0;
            for (int c = 0; c < len; c++) begin
                v = ($urandom_range(0, 3) != 0);
                d = int'($urandom_range(0, 4000)) - 2000;
                case (kind)
                    K_SIG:  drive(SW_PC_SIGNAL, MUX_AZ_PC_OUT, v, d);
                    K_ZERO: drive(1'($urandom_range(0, 1)), MUX_AZ_ZERO, v, d);
                    default:
                        if ($urandom_range(0, 1) != 0) drive(SW_PC_BOOT, MUX_AZ_PC_OUT, v, d);
                        else drive(1'($urandom_range(0, 1)), 3'($urandom_range(1, 6)), v, d);
                endcase
                if (v) begin
                    seen++;
                    if (seen > SETTLE_N) begin sum += d; n++; end
                end
            end
            if (kind == K_SIG) begin
                pending = 1'b1; p_sum = sum; p_n = n;
            end else if (kind == K_ZERO) begin
                if (pending) expq.push_back('{cyc + 2, p_sum, sum, p_n, n});
                else         exp_orph = 1'b1;
                pending = 1'b0;
            end
            prev_kind = kind;
        end
        phase(K_NONE, 4, 0);
        rnd_mode = 1'b0;
        chk("rnd_leftover", expq.size(), 0);
        chk("rnd_orphan", err_orphan, exp_orph);
        chk("rnd_sat", err_sat, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/az_sample_collector.md
# az_sample_collector

Consumer side of the auto-zero modulation: watches the precharge-switch and AZ-mux controls driven by the AZ modulator and gates the ADC conversion stream into signal and zero accumulators. On each completed signal→zero pair it emits signal sum, zero sum, sample counts and the AZ-corrected difference as a one-cycle-valid result. It sits between the modulator/ADC front end and the register/readout logic.

## Interface
- `ADC_W`, 24: signed ADC sample width.
- `ACC_W`, 40: signed accumulator width.
- `CNT_W`, 16: unsigned per-phase sample counter width.
- `SETTLE_N`, 2: valid samples discarded at the start of each phase.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `sw_pc_ctl`  in  1  precharge switch control from the modulator.
- `mux_az`  in  3  AZ mux select from the modulator.
- `adc_valid`  in  1  one-cycle strobe; `adc_data` is valid.
- `adc_data`  in  ADC_W  signed conversion result.
- `out_valid`  out  1  one-cycle pulse; result fields are updated.
- `out_hi`  out  ACC_W  signed sum of signal-phase samples.
- `out_lo`  out  ACC_W  signed sum of zero-phase samples.
- `out_diff`  out  ACC_W  `out_hi - out_lo`, wrapping.
- `out_hi_n`, `out_lo_n`  out  CNT_W each  samples accumulated per phase.
- `err_orphan`  out  1  sticky: zero phase ended with no signal phase pending.
- `err_sat`  out  1  sticky: a counter saturated or an accumulator overflowed.
- `err_clear`  in  1  clears both sticky flags; `err_*` set on the same cycle wins.

## Operation
- Input stage: `sw_pc_ctl`, `mux_az`, `adc_valid` and `adc_data` are registered once together, so phase decode and sample stay aligned.
- Decode on the registered values:
  - `SIG` = `sw_pc_ctl == SW_PC_SIGNAL` && `mux_az == MUX_AZ_PC_OUT`.
  - `ZERO` = `mux_az == MUX_AZ_ZERO`.
  - `NONE` = anything else, including precharge/boot intervals.
- FSM states:
  - IDLE: on `SIG`, clear the signal accumulator and counters and go to SIG_ACC. On `ZERO`, go to ZERO_ORPHAN.
  - SIG_ACC: accumulate. When the phase leaves `SIG`, latch the signal sum and count and go to WAIT_ZERO.
  - WAIT_ZERO: on `ZERO`, clear the zero accumulator and go to ZERO_ACC. On `SIG` again, discard the held signal result and restart SIG_ACC.
  - ZERO_ACC: accumulate. When the phase leaves `ZERO`, go to EMIT.
  - EMIT: drive outputs and pulse `out_valid`, then return to IDLE. If the current decode is `SIG`, go directly to SIG_ACC instead.
  - ZERO_ORPHAN: wait for the phase to leave `ZERO`, then set `err_orphan` and return to IDLE.
- Accumulation in a phase state:
  - The first `SETTLE_N` valid samples are counted internally and dropped.
  - Each later sample is sign-extended to ACC_W, added to the sum, and increments the count.
- Counts saturate at all-ones; further samples are dropped and set `err_sat`.
- Accumulator signed overflow sets `err_sat`. The sum wraps and the pair is still emitted.
- A sample arriving on the cycle the decoded phase changes belongs to the new phase's decode.
- Continuous `SIG` mode and continuous `ZERO` (lo) mode never complete a pair, so no `out_valid` is produced; that is correct behaviour.
- Reset mid-phase discards all partial sums.

## Timing
- Reset values: FSM IDLE; all `out_*` 0; `out_valid` 0; `err_*` 0; input registers 0.
- Latency: `out_valid` rises 2 cycles after the first input cycle where `mux_az != MUX_AZ_ZERO` following a zero phase (1 cycle input register, 1 cycle EMIT).
- Result fields hold their values until the next `out_valid`.
- There is no backpressure. The downstream block must capture the result on `out_valid`.
- Minimum spacing between `out_valid` pulses is limited only by the phase lengths.
- A zero-length phase (one cycle with no `adc_valid`) still completes a pair and emits with counts 0.

## Structure
- Shared defines header: `MUX_AZ_PC_OUT` (0), `MUX_AZ_ZERO` (7), `SW_PC_SIGNAL` (1), `SW_PC_BOOT` (0). The modulator and this block use this one copy.
- Sub-module `az_phase_accumulator`, instantiated twice (signal and zero):
  - Inputs: clear, enable, valid, data.
  - Contains: settle-skip counter, saturating count, signed sum, overflow detect.
- The FSM and output registers live in the top module.

## Test plan
- Normal pair, SETTLE_N=2: 6 samples of +1000 in `SIG`, 2 `NONE` cycles, 6 samples of +10 in `ZERO` → `out_hi`=4000, `out_lo`=40, `out_diff`=3960, counts 4/4, one `out_valid`, asserted 2 cycles after `ZERO` ends.
- Negative values: signal samples −500 ×5, zero samples +20 ×5 → `out_hi`=−1500, `out_lo`=60, `out_diff`=−1560.
- Orphan zero: `ZERO` from IDLE for 10 samples, then `NONE` → `err_orphan`=1, no `out_valid`. Then assert `err_clear` → 0.
- Repeated `SIG`: `SIG`, `NONE`, `SIG` with samples 7 ×4, then `ZERO` with 3 ×4 → emits only the second signal phase: hi=14, lo=6.
- Saturation, CNT_W=4, SETTLE_N=0: 20 signal samples of 1 → `out_hi_n`=15, `out_hi`=15, `err_sat`=1.
- Reset asserted mid-ZERO_ACC → all outputs 0 the next cycle. A new full pair then emits correct values.
